// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_pkg;

   localparam int FETCH_DATA_W      = 8;
   localparam int FETCH_ADDR_W      = 8;
   localparam int FETCH_INSTR_BYTES = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_byte_assembler.sv
// Slot register that collects instruction bytes by index; slot 0 lands in the MSBs.
module fetch_byte_assembler #(
   parameter int DATA_W      = 8,
   parameter int INSTR_BYTES = 3,
   parameter int IDX_W       = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,      // active-low async
   input  logic                          i_clr,
   input  logic                          i_wr_en,
   input  logic [IDX_W-1:0]              i_wr_idx,
   input  logic [DATA_W-1:0]             i_wr_data,
   output logic [INSTR_BYTES*DATA_W-1:0] o_packed
);

   logic [DATA_W-1:0] r_slot [INSTR_BYTES];

   // Slot storage: clear wins over write so a flushed instruction never leaks.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int k = 0; k < INSTR_BYTES; k++) r_slot[k] <= '0;
      end else if (i_clr) begin
         for (int k = 0; k < INSTR_BYTES; k++) r_slot[k] <= '0;
      end else if (i_wr_en) begin
         for (int k = 0; k < INSTR_BYTES; k++)
            if (i_wr_idx == IDX_W'(k)) r_slot[k] <= i_wr_data;
      end
   end

   // Pack slots with the opcode (slot 0) in the most significant position.
   always_comb begin
      o_packed = '0;
      for (int k = 0; k < INSTR_BYTES; k++)
         o_packed[(INSTR_BYTES-1-k)*DATA_W +: DATA_W] = r_slot[k];
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: reads INSTR_BYTES words per instruction from
// synchronous-read memory and offers the packed word over valid/ready.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | halted, no reads; leaves when fetch is enabled
//  ST_FETCH | issuing reads pc..pc+N-1 and capturing returning data
//  ST_VALID | complete instruction offered, held until accepted
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              DATA_W      = FETCH_DATA_W,
   parameter int              ADDR_W      = FETCH_ADDR_W,
   parameter int              INSTR_BYTES = FETCH_INSTR_BYTES,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic                          i_clk,
   input  logic                          i_rst,          // active-low async
   input  logic                          i_fetch_en,
   input  logic                          i_pc_load_en,
   input  logic [ADDR_W-1:0]             i_pc_load_addr,
   output logic                          o_mem_rd_en,
   output logic [ADDR_W-1:0]             o_mem_rd_addr,
   input  logic [DATA_W-1:0]             i_mem_rd_data,
   output logic                          o_instr_valid,
   input  logic                          i_instr_ready,
   output logic [INSTR_BYTES*DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0]             o_instr_pc,
   output logic [ADDR_W-1:0]             o_pc
);

   localparam int CNT_W = $clog2(INSTR_BYTES + 1);
   localparam int IDX_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
   localparam logic [CNT_W-1:0] LP_CNT_END = CNT_W'(INSTR_BYTES);
   localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(INSTR_BYTES - 1);

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_instr_valid;
   logic [CNT_W-1:0]  r_issue_cnt;
   logic              r_cap_pend;
   logic [IDX_W-1:0]  r_cap_idx;

   logic w_issue;
   logic w_cap_wr;
   logic w_cap_last;

   // Read strobe and address decoded straight from state and issue pointer.
   always_comb begin
      w_issue       = (r_state == ST_FETCH) && (r_issue_cnt < LP_CNT_END);
      o_mem_rd_en   = w_issue;
      o_mem_rd_addr = r_pc + ADDR_W'(r_issue_cnt);
      w_cap_wr      = r_cap_pend && !i_pc_load_en;
      w_cap_last    = w_cap_wr && (r_cap_idx == LP_IDX_LAST);
   end

   // Sequencer: jump has top priority, then the per-state behaviour.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state       <= ST_IDLE;
         r_pc          <= RESET_PC;
         r_instr_pc    <= RESET_PC;
         r_instr_valid <= 1'b0;
         r_issue_cnt   <= '0;
         r_cap_pend    <= 1'b0;
         r_cap_idx     <= '0;
      end else if (i_pc_load_en) begin
         r_pc          <= i_pc_load_addr;
         r_issue_cnt   <= '0;
         r_cap_pend    <= 1'b0;
         r_instr_valid <= 1'b0;
         r_state       <= i_fetch_en ? ST_FETCH : ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_issue_cnt <= '0;
               r_cap_pend  <= 1'b0;
               if (i_fetch_en) r_state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (w_issue) begin
                  r_issue_cnt <= r_issue_cnt + 1'b1;
                  r_cap_pend  <= 1'b1;
                  r_cap_idx   <= IDX_W'(r_issue_cnt);
               end else begin
                  r_cap_pend  <= 1'b0;
               end
               if (w_cap_last) begin
                  r_instr_valid <= 1'b1;
                  r_instr_pc    <= r_pc;
                  r_pc          <= r_pc + ADDR_W'(INSTR_BYTES);
                  r_issue_cnt   <= '0;
                  r_state       <= ST_VALID;
               end
            end
            ST_VALID: begin
               if (i_instr_ready) begin
                  r_instr_valid <= 1'b0;
                  r_state       <= i_fetch_en ? ST_FETCH : ST_IDLE;
               end
            end
            default: begin
               r_instr_valid <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   fetch_byte_assembler #(
      .DATA_W      (DATA_W),
      .INSTR_BYTES (INSTR_BYTES),
      .IDX_W       (IDX_W)
   ) u_asm (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (i_pc_load_en),
      .i_wr_en   (w_cap_wr),
      .i_wr_idx  (r_cap_idx),
      .i_wr_data (i_mem_rd_data),
      .o_packed  (o_instr)
   );

   assign o_instr_valid = r_instr_valid;
   assign o_instr_pc    = r_instr_pc;
   assign o_pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous-read memory model.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        fetch_en;
   logic        pc_load_en;
   logic [7:0]  pc_load_addr;
   logic        mem_rd_en;
   logic [7:0]  mem_rd_addr;
   logic [7:0]  mem_rd_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [23:0] instr;
   logic [7:0]  instr_pc;
   logic [7:0]  pc;

   logic [7:0]  mem [256];
   int          n_chk;
   int          n_pass;
   int          rd_cnt;
   int          lat;
   int          snap;

   fetch_unit dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_fetch_en     (fetch_en),
      .i_pc_load_en   (pc_load_en),
      .i_pc_load_addr (pc_load_addr),
      .o_mem_rd_en    (mem_rd_en),
      .o_mem_rd_addr  (mem_rd_addr),
      .i_mem_rd_data  (mem_rd_data),
      .o_instr_valid  (instr_valid),
      .i_instr_ready  (instr_ready),
      .o_instr        (instr),
      .o_instr_pc     (instr_pc),
      .o_pc           (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      if (rst && mem_rd_en) rd_cnt = rd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!instr_valid && n < 20) begin
         step();
         n++;
      end
      chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; rd_cnt = 0;
      mem_rd_data = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[8'h00] = 8'hA1; mem[8'h01] = 8'hB2; mem[8'h02] = 8'hC3;
      mem[8'h03] = 8'hD4; mem[8'h04] = 8'hE5; mem[8'h05] = 8'hF6;
      mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33;
      mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'h6B;

      rst = 1'b0; fetch_en = 1'b0; pc_load_en = 1'b0; pc_load_addr = 8'h00; instr_ready = 1'b0;
      step(); step();
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      chk("rst_pc", {24'd0, pc}, 32'h00);
      chk("rst_instr", {8'd0, instr}, 32'h0);
      chk("rst_instr_pc", {24'd0, instr_pc}, 32'h00);
      chk("rst_rd_addr", {24'd0, mem_rd_addr}, 32'h00);

      rst = 1'b1;
      step(); step();
      chk("idle_no_read", {31'd0, mem_rd_en}, 32'd0);

      // basic fetch, held under backpressure
      fetch_en = 1'b1;
      step();
      chk("fetch_rd_en", {31'd0, mem_rd_en}, 32'd1);
      chk("fetch_rd_addr0", {24'd0, mem_rd_addr}, 32'h00);
      wait_valid(lat);
      chk("latency", lat, 32'd4);
      chk("basic_instr", {8'd0, instr}, 32'hA1B2C3);
      chk("basic_instr_pc", {24'd0, instr_pc}, 32'h00);
      chk("basic_pc", {24'd0, pc}, 32'h03);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_valid", {31'd0, instr_valid}, 32'd1);
         chk("bp_instr", {8'd0, instr}, 32'hA1B2C3);
         chk("bp_no_read", {31'd0, mem_rd_en}, 32'd0);
      end

      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("acc_valid_drop", {31'd0, instr_valid}, 32'd0);
      chk("acc_rd_addr", {24'd0, mem_rd_addr}, 32'h03);
      wait_valid(lat);
      chk("second_instr", {8'd0, instr}, 32'hD4E5F6);
      chk("second_instr_pc", {24'd0, instr_pc}, 32'h03);
      chk("second_pc", {24'd0, pc}, 32'h06);

      // jump after two reads
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      step();
      pc_load_en = 1'b1; pc_load_addr = 8'h40;
      step();
      pc_load_en = 1'b0;
      chk("jmp_valid", {31'd0, instr_valid}, 32'd0);
      chk("jmp_pc", {24'd0, pc}, 32'h40);
      chk("jmp_rd_addr", {24'd0, mem_rd_addr}, 32'h40);
      wait_valid(lat);
      chk("jmp_latency", lat, 32'd4);
      chk("jmp_instr", {8'd0, instr}, 32'h112233);
      chk("jmp_instr_pc", {24'd0, instr_pc}, 32'h40);
      chk("jmp_next_pc", {24'd0, pc}, 32'h43);

      // jump from VALID to the top of memory
      pc_load_en = 1'b1; pc_load_addr = 8'hFE;
      step();
      pc_load_en = 1'b0;
      chk("wrap_valid", {31'd0, instr_valid}, 32'd0);
      chk("wrap_addr0", {24'd0, mem_rd_addr}, 32'hFE);
      step();
      chk("wrap_addr1", {24'd0, mem_rd_addr}, 32'hFF);
      step();
      chk("wrap_addr2", {24'd0, mem_rd_addr}, 32'h00);
      wait_valid(lat);
      chk("wrap_instr", {8'd0, instr}, 32'h5A6BA1);
      chk("wrap_instr_pc", {24'd0, instr_pc}, 32'hFE);
      chk("wrap_pc", {24'd0, pc}, 32'h01);

      // halt: pending instruction still offered, then no reads
      fetch_en = 1'b0;
      step();
      chk("halt_hold_valid", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("halt_valid_drop", {31'd0, instr_valid}, 32'd0);
      snap = rd_cnt;
      for (int c = 0; c < 5; c++) step();
      chk("halt_no_reads", rd_cnt - snap, 32'd0);
      chk("halt_pc", {24'd0, pc}, 32'h01);

      // resume, then jump coincident with handshake
      fetch_en = 1'b1;
      step();
      wait_valid(lat);
      chk("resume_instr", {8'd0, instr}, 32'hB2C3D4);
      chk("resume_instr_pc", {24'd0, instr_pc}, 32'h01);
      instr_ready = 1'b1; pc_load_en = 1'b1; pc_load_addr = 8'h40;
      step();
      instr_ready = 1'b0; pc_load_en = 1'b0;
      chk("jh_valid", {31'd0, instr_valid}, 32'd0);
      chk("jh_pc", {24'd0, pc}, 32'h40);

      // asynchronous reset in the middle of a fetch
      step();
      chk("pre_rst_rd_en", {31'd0, mem_rd_en}, 32'd1);
      rst = 1'b0;
      #1;
      chk("arst_valid", {31'd0, instr_valid}, 32'd0);
      chk("arst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      chk("arst_pc", {24'd0, pc}, 32'h00);
      chk("arst_instr", {8'd0, instr}, 32'h0);
      fetch_en = 1'b0;
      step();
      rst = 1'b1;
      snap = rd_cnt;
      for (int c = 0; c < 4; c++) step();
      chk("post_rst_no_reads", rd_cnt - snap, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
